// File: rtl/tdm_display_scanner.sv
// Scans a 32-bit page word onto an 8-digit common-anode 7-segment display and drives the upstream page select.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading-zero digits 1..7).
module tdm_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int PAGE_FRAMES = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] data_in,
   input  logic        page_hold,
   output logic        page_sel,
   output logic [7:0]  anode_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FRM_MAX = FW'(PAGE_FRAMES - 1);

   logic [PW-1:0] r_prescaler;
   logic [2:0]    r_digit;
   logic [FW-1:0] r_frameCnt;
   logic          r_pageSel;
   logic [31:0]   r_snapshot;
   logic          r_loadQ;
   logic [7:0]    r_anodeN;
   logic [6:0]    r_segN;
   logic          r_frameStart;

   logic          w_tick;
   logic          w_frameWrap;
   logic [3:0]    w_nibble;
   logic [6:0]    w_segCode;
   logic          w_blank;

   assign w_tick      = (r_prescaler == PRE_MAX);
   assign w_frameWrap = w_tick && (r_digit == 3'd7);

   always_comb begin
      w_nibble = r_snapshot[{r_digit, 2'b00} +: 4];
   end

   // Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
   always_comb begin
      w_segCode = 7'h7F;
      unique case (w_nibble)
         4'h0: w_segCode = 7'b1000000;
         4'h1: w_segCode = 7'b1111001;
         4'h2: w_segCode = 7'b0100100;
         4'h3: w_segCode = 7'b0110000;
         4'h4: w_segCode = 7'b0011001;
         4'h5: w_segCode = 7'b0010010;
         4'h6: w_segCode = 7'b0000010;
         4'h7: w_segCode = 7'b1111000;
         4'h8: w_segCode = 7'b0000000;
         4'h9: w_segCode = 7'b0010000;
         4'hA: w_segCode = 7'b0001000;
         4'hB: w_segCode = 7'b0000011;
         4'hC: w_segCode = 7'b1000110;
         4'hD: w_segCode = 7'b0100001;
         4'hE: w_segCode = 7'b0000110;
         4'hF: w_segCode = 7'b0001110;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
   always_comb begin
      w_blank = (r_digit != 3'd0) && ((r_snapshot >> {r_digit, 2'b00}) == 32'h0);
   end
`else
   always_comb begin
      w_blank = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_prescaler <= '0;
         r_digit     <= 3'd0;
      end else begin
         if (w_tick) begin
            r_prescaler <= '0;
            r_digit     <= r_digit + 3'd1;
         end else begin
            r_prescaler <= r_prescaler + 1'b1;
         end
      end
   end

   // page_hold only matters at the frame wrap that closes a page; frames keep counting while held.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_frameCnt <= '0;
         r_pageSel  <= 1'b0;
      end else if (w_frameWrap) begin
         if (r_frameCnt == FRM_MAX) begin
            r_frameCnt <= '0;
            if (!page_hold) begin
               r_pageSel <= ~r_pageSel;
            end
         end else begin
            r_frameCnt <= r_frameCnt + 1'b1;
         end
      end
   end

   // The snapshot loads one cycle after the wrap so the upstream mux can settle on the new page_sel.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_snapshot   <= 32'h0;
         r_loadQ      <= 1'b1;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= r_loadQ;
         if (r_loadQ) begin
            r_snapshot <= data_in;
            r_loadQ    <= 1'b0;
         end
         if (w_frameWrap) begin
            r_loadQ <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_anodeN <= 8'hFF;
         r_segN   <= 7'h7F;
      end else if (w_blank) begin
         r_anodeN <= 8'hFF;
         r_segN   <= 7'h7F;
      end else begin
         r_anodeN <= ~(8'b1 << r_digit);
         r_segN   <= w_segCode;
      end
   end

   assign page_sel    = r_pageSel;
   assign anode_n     = r_anodeN;
   assign seg_n       = r_segN;
   assign dp_n        = 1'b1;
   assign frame_start = r_frameStart;

endmodule
